mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one sequential 8x8 unsigned multiplier
//  (start/busy/product interface) among NREQ requesters. Latches the winner's
//  operands, issues a one-cycle start, tracks busy, and returns the product with
//  a one-cycle done pulse. Sits between client FSMs and the single mult instance.
// PARAMETERS
//  NREQ     4   number of requesters, 2..8
//  TIMEOUT  16  watchdog limit in cycles per operation (used only with MULT_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-high; clears all state
//  req           in   NREQ     per-requester request level
//  req_a         in   8*NREQ   operand A, requester i on bits [8i+7:8i]
//  req_b         in   8*NREQ   operand B, same packing
//  grant         out  NREQ     one-hot, owner of current operation; 0 when idle
//  done          out  NREQ     one-hot, one-cycle completion pulse
//  resp_product  out  16       product of last completed operation
//  err           out  1        one-cycle pulse with done on watchdog abort
//  mult_start    out  1        to multiplier start
//  mult_a        out  8        to multiplier a
//  mult_b        out  8        to multiplier b
//  mult_rst      out  1        to multiplier reset
//  mult_busy     in   1        from multiplier busy
//  mult_product  in   16       from multiplier product
// BEHAVIOUR
//  - All outputs registered. Reset value 0 for all; ptr=0, state=IDLE.
//  - FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//    IDLE: if |req, pick first set bit at or after ptr (cyclic); latch index,
//      mult_a/mult_b from its operands; set grant, mult_start=1; -> ISSUE.
//    ISSUE: mult_start=0; -> WAIT_BUSY.
//    WAIT_BUSY: stay until mult_busy=1; -> WAIT_DONE.
//    WAIT_DONE: on mult_busy=0: resp_product<=mult_product, done[idx]=1,
//      grant<=0, ptr<=idx+1 mod NREQ; -> IDLE.
//  - mult_start high exactly one cycle per operation; never while busy.
//  - Latency: req sampled at edge E0 -> done[i] high in cycle after E0+11
//    (9 multiplier WORK cycles). Back-to-back: next grant at edge after done.
//  - Operands captured at grant; later changes to req_a/req_b have no effect.
//  - req dropped mid-operation: operation still completes, done still pulses.
//  - Requester keeping req high after done re-competes; ptr past it, so all
//    other pending requesters are served first (no starvation).
//  - resp_product holds until next completion. done and err are pulses.
//  - Async reset mid-operation: FSM, grant, done, mult_start cleared
//    immediately; mult_rst held 1 while reset asserted; no done for the
//    aborted operation.
//  - Product width: 16 bits, unsigned, no truncation; 255*255 = 0xFE01.
// CONFIGURATION
//  MULT_ARB_TIMEOUT_EN defined: counter starts at ISSUE; if
//    WAIT_BUSY/WAIT_DONE not left within TIMEOUT cycles, pulse mult_rst 1 cycle,
//    done[idx]=1, err=1, resp_product=0, advance ptr, -> IDLE.
//  Not defined: no counter; err tied 0; mult_rst = reset only; FSM waits
//    indefinitely on mult_busy.
// TESTING
//  1 Single req[0], a=0x0C, b=0x0A -> grant=0001, one mult_start, done[0] at
//    E0+11, resp_product=0x0078.
//  2 req=1111 held, distinct operands -> service order 0,1,2,3,0; each done
//    matches its own a*b; never two grant bits set.
//  3 Edges: a=0xFF,b=0xFF -> 0xFE01; a=0x00,b=0xA5 -> 0x0000.
//  4 Change req_a/req_b and drop req one cycle after grant -> done still
//    pulses, product from latched operands.
//  5 Assert reset during WAIT_DONE -> all outputs 0 at once, no done; next
//    req after release served normally from ptr=0.
//  6 (MULT_ARB_TIMEOUT_EN) hold mult_busy=1 -> after 16 cycles mult_rst
//    pulse, done+err, resp_product=0, FSM back to IDLE.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: client request/response bus plus the shared-multiplier port of mult_arbiter.
// slave is the arbiter's view; master is the environment's (clients and multiplier).
interface mult_arbiter_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [15:0]       resp_product;
    logic              err;
    logic              mult_start;
    logic [7:0]        mult_a;
    logic [7:0]        mult_b;
    logic              mult_rst;
    logic              mult_busy;
    logic [15:0]       mult_product;
    modport slave (
        input  req, req_a, req_b, mult_busy, mult_product,
        output grant, done, resp_product, err, mult_start, mult_a, mult_b, mult_rst
    );
    modport master (
        output req, req_a, req_b, mult_busy, mult_product,
        input  grant, done, resp_product, err, mult_start, mult_a, mult_b, mult_rst
    );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one sequential 8x8 multiplier among NREQ requesters.
// Optional per-operation watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [IW-1:0]   r_ptr, r_idx;
    logic [NREQ-1:0] r_grant, r_done;
    logic [15:0]     r_prod;
    logic            r_start;
    logic [7:0]      r_a, r_b;
    logic [IW-1:0]   w_idx, w_j, w_next;

    // Scan downward so the candidate closest to r_ptr (cyclically) is assigned last and wins.
    always_comb begin
        w_idx = r_ptr;
        w_j   = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = IW'((int'(r_ptr) + k) % NREQ);
            w_idx = bus.req[w_j] ? w_j : w_idx;
        end
    end

    assign w_next = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err, r_wd_rst;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_prod  <= '0;
            r_start <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_wd_rst <= 1'b0;
`endif
        end else begin
            r_done  <= '0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: if (|bus.req) begin
                    r_idx   <= w_idx;
                    r_a     <= bus.req_a[8*w_idx +: 8];
                    r_b     <= bus.req_b[8*w_idx +: 8];
                    r_grant <= NREQ'(1) << w_idx;
                    r_start <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_ISSUE:     r_state <= S_WAIT_BUSY;
                S_WAIT_BUSY: if (bus.mult_busy) r_state <= S_WAIT_DONE;
                default: if (!bus.mult_busy) begin
                    r_prod  <= bus.mult_product;
                    r_done  <= NREQ'(1) << r_idx;
                    r_grant <= '0;
                    r_ptr   <= w_next;
                    r_state <= S_IDLE;
                end
            endcase
`ifdef MULT_ARB_TIMEOUT_EN
            r_err    <= 1'b0;
            r_wd_rst <= 1'b0;
            r_cnt    <= (r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
            // Abort overrides a same-cycle normal completion.
            if ((r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) && r_cnt == CW'(TIMEOUT - 1)) begin
                r_wd_rst <= 1'b1;
                r_err    <= 1'b1;
                r_done   <= NREQ'(1) << r_idx;
                r_prod   <= '0;
                r_grant  <= '0;
                r_ptr    <= w_next;
                r_state  <= S_IDLE;
            end
`endif
        end
    end

    assign bus.grant        = r_grant;
    assign bus.done         = r_done;
    assign bus.resp_product = r_prod;
    assign bus.mult_start   = r_start;
    assign bus.mult_a       = r_a;
    assign bus.mult_b       = r_b;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.err      = r_err;
    assign bus.mult_rst = reset | r_wd_rst;
`else
    assign bus.err      = 1'b0;
    assign bus.mult_rst = reset;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed/randomized bench for mult_arbiter with a behavioural multiplier
// and a round-robin reference model.
module tb_mult_arbiter;
    localparam int NREQ = 4;
    logic clk = 1'b0, reset = 1'b0, mult_hang = 1'b0;
    int checks = 0, errors = 0, n_start = 0, n_done = 0, ptr_m = 0, m_cnt = 0, d0 = 0;
    logic [7:0] op_a [NREQ];
    logic [7:0] op_b [NREQ];
    logic [7:0] m_a, m_b;

    mult_arbiter_if #(.NREQ(NREQ)) bus ();
    mult_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    // Multiplier: busy for 9 cycles after the start edge, product valid when busy falls.
    always @(posedge clk or posedge reset) begin
        if (reset || bus.mult_rst) begin
            bus.mult_busy    <= 1'b0;
            bus.mult_product <= '0;
            m_cnt            <= 0;
        end else if (bus.mult_start && !bus.mult_busy) begin
            bus.mult_busy <= 1'b1;
            m_cnt         <= 8;
            m_a           <= bus.mult_a;
            m_b           <= bus.mult_b;
        end else if (bus.mult_busy && !mult_hang) begin
            if (m_cnt == 0) begin
                bus.mult_busy    <= 1'b0;
                bus.mult_product <= 16'(m_a) * 16'(m_b);
            end else m_cnt <= m_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if (bus.mult_start) n_start++;
        if (|bus.done) n_done++;
        check("grant_onehot", 16'($onehot0(bus.grant)), 16'd1);
        check("start_while_busy", 16'(bus.mult_start & bus.mult_busy), 16'd0);
    end

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    task automatic put_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[8*i +: 8] = op_a[i];
            bus.req_b[8*i +: 8] = op_b[i];
        end
    endtask

    // mode 0: keep req; 1: drop req right after grant; 2: drop req and scramble operands a cycle later
    task automatic op(input int mode, input logic to);
        int idx, lat, s0;
        logic [15:0] ep;
        idx = pick(bus.req, ptr_m);
        ep  = to ? 16'd0 : 16'(op_a[idx]) * 16'(op_b[idx]);
        s0  = n_start;
        @(posedge clk); #1;
        check("grant", 16'(bus.grant), 16'(1 << idx));
        check("start", 16'(bus.mult_start), 16'd1);
        check("mult_a", 16'(bus.mult_a), 16'(op_a[idx]));
        check("mult_b", 16'(bus.mult_b), 16'(op_b[idx]));
        lat = 0;
        if (mode == 1) bus.req = '0;
        if (mode == 2) begin
            @(posedge clk); #1;
            lat = 1;
            bus.req = '0;
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = 8'($urandom);
                op_b[i] = 8'($urandom);
            end
            put_ops();
        end
        while (lat < 40 && !(|bus.done)) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 16'(lat), to ? 16'd16 : 16'd11);
        check("done", 16'(bus.done), 16'(1 << idx));
        check("product", bus.resp_product, ep);
        check("err", 16'(bus.err), 16'(to));
        check("grant_clear", 16'(bus.grant), 16'd0);
        check("one_start", 16'(n_start - s0), 16'd1);
        ptr_m = (idx + 1) % NREQ;
    endtask

    initial begin
        reset = 1'b1;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        put_ops();
        repeat (2) @(negedge clk);
        check("rst_grant", 16'(bus.grant), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_product", bus.resp_product, 16'd0);
        check("rst_start", 16'(bus.mult_start), 16'd0);
        check("rst_err", 16'(bus.err), 16'd0);
        check("rst_mult_rst", 16'(bus.mult_rst), 16'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mult_rst_low", 16'(bus.mult_rst), 16'd0);

        // single requester, fixed operands
        op_a[0] = 8'h0C; op_b[0] = 8'h0A; put_ops();
        bus.req = 4'b0001;
        op(1, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", 16'(bus.done), 16'd0);
        check("product_hold", bus.resp_product, 16'h0078);

        // all requesters held, randomized operands, back-to-back service
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 8'($urandom);
            op_b[i] = 8'($urandom);
        end
        put_ops();
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) op(0, 1'b0);
        bus.req = '0;

        // operand extremes
        @(negedge clk);
        op_a[2] = 8'hFF; op_b[2] = 8'hFF; put_ops();
        bus.req = 4'b0100;
        op(1, 1'b0);
        @(negedge clk);
        op_a[2] = 8'h00; op_b[2] = 8'hA5; put_ops();
        bus.req = 4'b0100;
        op(1, 1'b0);

        // operands change and req drops after grant
        @(negedge clk);
        op_a[1] = 8'($urandom); op_b[1] = 8'($urandom); put_ops();
        bus.req = 4'b0010;
        op(2, 1'b0);

        // reset in the middle of an operation
        @(negedge clk);
        bus.req = 4'b0100;
        @(posedge clk); #1;
        check("abort_grant", 16'(bus.grant), 16'd4);
        bus.req = '0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        d0 = n_done;
        check("abort_grant_clr", 16'(bus.grant), 16'd0);
        check("abort_done", 16'(bus.done), 16'd0);
        check("abort_start", 16'(bus.mult_start), 16'd0);
        check("abort_product", bus.resp_product, 16'd0);
        check("abort_mult_rst", 16'(bus.mult_rst), 16'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        repeat (15) @(negedge clk);
        check("abort_no_done", 16'(n_done - d0), 16'd0);
        op_a[1] = 8'($urandom); op_b[1] = 8'($urandom);
        op_a[3] = 8'($urandom); op_b[3] = 8'($urandom); put_ops();
        bus.req = 4'b1010;
        op(1, 1'b0);

`ifdef MULT_ARB_TIMEOUT_EN
        // multiplier stuck busy
        @(negedge clk);
        mult_hang = 1'b1;
        bus.req = 4'b0001;
        op(1, 1'b1);
        check("wd_mult_rst", 16'(bus.mult_rst), 16'd1);
        mult_hang = 1'b0;
        @(posedge clk); #1;
        check("wd_mult_rst_pulse", 16'(bus.mult_rst), 16'd0);
        check("wd_err_pulse", 16'(bus.err), 16'd0);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
